// File: rtl/spi_slave.sv
//==============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI responder. SCK, CS_n and MOSI are synchronised
//            into i_Clk and edge-detected, so every flop runs on i_Clk.
//            Supports SPI modes 0-3 and LSB/MSB-first framing. Bursts of
//            bytes continue for as long as CS_n stays low.
// Ports    : i_Clk, i_Rst_L      - system clock, async active-low reset
//            i_TX_Byte/i_TX_DV   - byte to return on MISO (one-cycle qualifier)
//            o_TX_Ready          - TX holding register is empty
//            o_RX_DV/o_RX_Byte   - one-cycle pulse with the received byte
//            o_CS_Active         - synchronised chip-select is asserted
//            i_SPI_Clk/i_SPI_CS_n/i_SPI_MOSI/o_SPI_MISO - serial link
// Options  : SPI_SLAVE_MISO_HIZ_EN - when defined, MISO floats (1'bz) while
//            the slave is not selected, so several slaves can share MISO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_slave #(
  parameter int         SPI_MODE   = 0,
  parameter bit         LSB_FIRST  = 1'b1,
  parameter logic [7:0] TX_DEFAULT = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_CS_Active,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO
);

  localparam logic c_CPOL = SPI_MODE[1];
  localparam logic c_CPHA = SPI_MODE[0];

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchronisers (third SCK flop gives the previous value for edge detect)
  logic r_SCK_s1, r_SCK_s2, r_SCK_s3;
  logic r_CSn_s1, r_CSn_s2;
  logic r_MOSI_s1, r_MOSI_s2;

  logic [0:0] r_State, w_State_Next;

  logic       w_Lead, w_Trail, w_Sample, w_Enter, w_Exit, w_Load;
  logic [7:0] w_Load_Byte, w_RX_Shift_Next;

  logic [7:0] r_RX_Shift, r_RX_Byte;
  logic [2:0] r_RX_Cnt, r_Trail_Cnt;
  logic       r_RX_Done, r_RX_DV;

  logic [7:0] r_TX_Hold, r_TX_Shift;
  logic       r_TX_Full;
  logic [2:0] r_TX_Idx;
  logic       r_MISO;

  // Bit of a byte that goes out in serial position idx
  function automatic logic f_TX_Bit(input logic [7:0] b, input logic [2:0] idx);
    if (LSB_FIRST) f_TX_Bit = b[idx];
    else           f_TX_Bit = b[3'd7 - idx];
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_SCK_s1  <= c_CPOL;
      r_SCK_s2  <= c_CPOL;
      r_SCK_s3  <= c_CPOL;
      r_CSn_s1  <= 1'b1;
      r_CSn_s2  <= 1'b1;
      r_MOSI_s1 <= 1'b0;
      r_MOSI_s2 <= 1'b0;
    end else begin
      r_SCK_s1  <= i_SPI_Clk;
      r_SCK_s2  <= r_SCK_s1;
      r_SCK_s3  <= r_SCK_s2;
      r_CSn_s1  <= i_SPI_CS_n;
      r_CSn_s2  <= r_CSn_s1;
      r_MOSI_s1 <= i_SPI_MOSI;
      r_MOSI_s2 <= r_MOSI_s1;
    end
  end

  // Edges count only while selected; the cycle CS rises is already a release
  assign w_Lead   = (r_State == ST_ACTIVE) && !r_CSn_s2 &&
                    (r_SCK_s3 == c_CPOL) && (r_SCK_s2 != c_CPOL);
  assign w_Trail  = (r_State == ST_ACTIVE) && !r_CSn_s2 &&
                    (r_SCK_s3 != c_CPOL) && (r_SCK_s2 == c_CPOL);
  assign w_Sample = c_CPHA ? w_Trail : w_Lead;
  assign w_Enter  = (r_State == ST_IDLE) && !r_CSn_s2;
  assign w_Exit   = (r_State == ST_ACTIVE) && r_CSn_s2;
  // New TX byte at selection and after the last trailing edge of each byte
  assign w_Load   = w_Enter || (w_Trail && (r_Trail_Cnt == 3'd7));

  assign w_Load_Byte     = r_TX_Full ? r_TX_Hold : TX_DEFAULT;
  assign w_RX_Shift_Next = LSB_FIRST ? {r_MOSI_s2, r_RX_Shift[7:1]}
                                     : {r_RX_Shift[6:0], r_MOSI_s2};

  // FSM: state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= ST_IDLE;
    else          r_State <= w_State_Next;
  end

  // FSM: next state
  always_comb begin
    w_State_Next = r_State;
    case (r_State)
      ST_IDLE:   if (!r_CSn_s2) w_State_Next = ST_ACTIVE;
      ST_ACTIVE: if (r_CSn_s2)  w_State_Next = ST_IDLE;
      default:   w_State_Next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_CS_Active = (r_State == ST_ACTIVE);
`ifdef SPI_SLAVE_MISO_HIZ_EN
    o_SPI_MISO  = (r_State == ST_ACTIVE) ? r_MISO : 1'bz;
`else
    o_SPI_MISO  = (r_State == ST_ACTIVE) & r_MISO;
`endif
  end

  // Receive path. The shifter itself is never cleared: the bit counter
  // restarting at 0 guarantees a full overwrite, and leaving it alone lets a
  // byte completed just before CS rises still be published.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_RX_Shift  <= 8'h00;
      r_RX_Byte   <= 8'h00;
      r_RX_Cnt    <= 3'd0;
      r_Trail_Cnt <= 3'd0;
      r_RX_Done   <= 1'b0;
      r_RX_DV     <= 1'b0;
    end else begin
      r_RX_DV   <= r_RX_Done;
      r_RX_Done <= 1'b0;
      if (r_RX_Done) r_RX_Byte <= r_RX_Shift;
      if ((r_State != ST_ACTIVE) || w_Exit) begin
        r_RX_Cnt    <= 3'd0;
        r_Trail_Cnt <= 3'd0;
      end else begin
        if (w_Sample) begin
          r_RX_Shift <= w_RX_Shift_Next;
          r_RX_Cnt   <= r_RX_Cnt + 3'd1;
          if (r_RX_Cnt == 3'd7) r_RX_Done <= 1'b1;
        end
        if (w_Trail) r_Trail_Cnt <= r_Trail_Cnt + 3'd1;
      end
    end
  end

  // Transmit path. A load empties the holding register; a TX_DV seen while
  // it was empty (even in the load cycle) refills it for the next byte.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_TX_Hold  <= 8'h00;
      r_TX_Full  <= 1'b0;
      r_TX_Shift <= 8'h00;
      r_TX_Idx   <= 3'd0;
      r_MISO     <= 1'b0;
    end else begin
      if (w_Load) r_TX_Full <= 1'b0;
      if (i_TX_DV && !r_TX_Full) begin
        r_TX_Hold <= i_TX_Byte;
        r_TX_Full <= 1'b1;
      end

      if (w_Exit) begin
        r_TX_Idx <= 3'd0;
        r_MISO   <= 1'b0;
      end else if (w_Load) begin
        r_TX_Shift <= w_Load_Byte;
        r_MISO     <= f_TX_Bit(w_Load_Byte, 3'd0);
        // CPHA=0 has already presented bit 0; CPHA=1 re-drives it on the
        // first leading edge.
        r_TX_Idx   <= c_CPHA ? 3'd0 : 3'd1;
      end else if (c_CPHA ? w_Lead : w_Trail) begin
        r_MISO   <= f_TX_Bit(r_TX_Shift, r_TX_Idx);
        r_TX_Idx <= r_TX_Idx + 3'd1;
      end
    end
  end

  assign o_TX_Ready = ~r_TX_Full;
  assign o_RX_DV    = r_RX_DV;
  assign o_RX_Byte  = r_RX_Byte;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
//==============================================================================
// Module   : tb_spi_slave
// Purpose  : Directed self-checking bench for spi_slave. Instance 0 runs
//            mode 0 LSB-first; instances 1-3 run modes 1-3 MSB-first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_slave;

  localparam int HALF = 80;   // SCK half period in ns (i_Clk period 10 ns)

  logic       clk;
  logic       rst_l;
  logic       mosi;
  logic [3:0] sck, cs_n, tx_dv;
  logic [7:0] tx_byte [4];
  wire  [3:0] miso, ready, rx_dv, csa;
  wire  [7:0] rx_byte [4];

  int checks = 0;
  int passes = 0;

  int         rx_cnt  [4] = '{default: 0};
  logic [7:0] rx_last [4];
  logic [7:0] rx_hist0 [16];

  spi_slave #(.SPI_MODE(0), .LSB_FIRST(1'b1), .TX_DEFAULT(8'hFF)) u_m0 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Byte(tx_byte[0]), .i_TX_DV(tx_dv[0]),
    .o_TX_Ready(ready[0]), .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
    .o_CS_Active(csa[0]), .i_SPI_Clk(sck[0]), .i_SPI_CS_n(cs_n[0]),
    .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[0]));

  spi_slave #(.SPI_MODE(1), .LSB_FIRST(1'b0), .TX_DEFAULT(8'hFF)) u_m1 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Byte(tx_byte[1]), .i_TX_DV(tx_dv[1]),
    .o_TX_Ready(ready[1]), .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
    .o_CS_Active(csa[1]), .i_SPI_Clk(sck[1]), .i_SPI_CS_n(cs_n[1]),
    .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[1]));

  spi_slave #(.SPI_MODE(2), .LSB_FIRST(1'b0), .TX_DEFAULT(8'hFF)) u_m2 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Byte(tx_byte[2]), .i_TX_DV(tx_dv[2]),
    .o_TX_Ready(ready[2]), .o_RX_DV(rx_dv[2]), .o_RX_Byte(rx_byte[2]),
    .o_CS_Active(csa[2]), .i_SPI_Clk(sck[2]), .i_SPI_CS_n(cs_n[2]),
    .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[2]));

  spi_slave #(.SPI_MODE(3), .LSB_FIRST(1'b0), .TX_DEFAULT(8'hFF)) u_m3 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Byte(tx_byte[3]), .i_TX_DV(tx_dv[3]),
    .o_TX_Ready(ready[3]), .o_RX_DV(rx_dv[3]), .o_RX_Byte(rx_byte[3]),
    .o_CS_Active(csa[3]), .i_SPI_Clk(sck[3]), .i_SPI_CS_n(cs_n[3]),
    .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive monitor: count and log every RX_DV pulse
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_dv[k] === 1'b1) begin
        if (k == 0 && rx_cnt[0] < 16) rx_hist0[rx_cnt[0]] = rx_byte[0];
        rx_last[k] = rx_byte[k];
        rx_cnt[k]  = rx_cnt[k] + 1;
      end
    end
  end

  task automatic load_tx(input int d, input logic [7:0] b);
    @(posedge clk); #1;
    tx_byte[d] = b;
    tx_dv[d]   = 1'b1;
    @(posedge clk); #1;
    tx_dv[d]   = 1'b0;
  endtask

  // Master side of nbits bit-times in instance d's mode
  task automatic spi_bits(input int d, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    logic cpol, cpha, lsb;
    int   idx;
    cpol = (d >= 2);
    cpha = (d == 1) || (d == 3);
    lsb  = (d == 0);
    mi   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        #HALF;
        mi[idx] = miso[d];
        sck[d]  = ~cpol;
        #HALF;
        sck[d]  = cpol;
      end else begin
        #HALF;
        sck[d]  = ~cpol;
        mosi    = mo[idx];
        #HALF;
        mi[idx] = miso[d];
        sck[d]  = cpol;
      end
    end
  endtask

  task automatic xfer(input int d, input logic [7:0] mo, output logic [7:0] mi);
    cs_n[d] = 1'b0;
    #HALF;
    spi_bits(d, mo, 8, mi);
    #HALF;
    cs_n[d] = 1'b1;
    #(4 * HALF);
  endtask

  task automatic test_reset();
    #23;
    checks++; if (ready[0] !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready[0]); else passes++;
    checks++; if (rx_dv[0] !== 1'b0) $display("FAIL reset_rx_dv: got %b want 0", rx_dv[0]); else passes++;
    checks++; if (rx_byte[0] !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", rx_byte[0]); else passes++;
    checks++; if (csa[0] !== 1'b0) $display("FAIL reset_cs_active: got %b want 0", csa[0]); else passes++;
    checks++; if (miso[0] !== 1'b0 && miso[0] !== 1'bz) $display("FAIL reset_miso: got %b want 0/z", miso[0]); else passes++;
    @(posedge clk); #1;
    rst_l = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int n, c0;
    c0 = rx_cnt[0];
    load_tx(0, 8'h3C);
    @(posedge clk); #1;
    cs_n[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (ready[0] !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ready[0] !== 1'b1) $display("FAIL m0_ready_rise: got %b want 1 within 4 cycles", ready[0]); else passes++;
    spi_bits(0, 8'hA5, 8, mi);
    #HALF;
    cs_n[0] = 1'b1;
    #(4 * HALF);
    checks++; if (rx_cnt[0] !== c0 + 1) $display("FAIL m0_rx_count: got %0d want %0d", rx_cnt[0], c0 + 1); else passes++;
    checks++; if (rx_last[0] !== 8'hA5) $display("FAIL m0_rx_byte: got %h want a5", rx_last[0]); else passes++;
    checks++; if (mi !== 8'h3C) $display("FAIL m0_miso_byte: got %h want 3c", mi); else passes++;
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    int c;
    for (int d = 1; d < 4; d++) begin
      c = rx_cnt[d];
      load_tx(d, 8'h7E);
      xfer(d, 8'h81, mi);
      checks++; if (rx_cnt[d] !== c + 1) $display("FAIL mode%0d_rx_count: got %0d want %0d", d, rx_cnt[d], c + 1); else passes++;
      checks++; if (rx_last[d] !== 8'h81) $display("FAIL mode%0d_rx_byte: got %h want 81", d, rx_last[d]); else passes++;
      checks++; if (mi !== 8'h7E) $display("FAIL mode%0d_miso_byte: got %h want 7e", d, mi); else passes++;
    end
    // SCK activity with CS_n high must be ignored
    c = rx_cnt[1];
    for (int i = 0; i < 16; i++) begin
      mosi   = i[0];
      sck[1] = ~sck[1];
      #HALF;
    end
    #(4 * HALF);
    checks++; if (rx_cnt[1] !== c) $display("FAIL idle_sck_rx_count: got %0d want %0d", rx_cnt[1], c); else passes++;
    checks++; if (csa[1] !== 1'b0) $display("FAIL idle_sck_cs_active: got %b want 0", csa[1]); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2, m3;
    int n, c0;
    c0 = rx_cnt[0];
    load_tx(0, 8'hAA);
    cs_n[0] = 1'b0;
    n = 0;
    while (ready[0] !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ready[0] !== 1'b1) $display("FAIL burst_ready: got %b want 1 within 8 cycles", ready[0]); else passes++;
    load_tx(0, 8'hBB);
    spi_bits(0, 8'h11, 8, m1);
    spi_bits(0, 8'h22, 8, m2);
    spi_bits(0, 8'h33, 8, m3);
    #HALF;
    cs_n[0] = 1'b1;
    #(4 * HALF);
    checks++; if (rx_cnt[0] !== c0 + 3) $display("FAIL burst_rx_count: got %0d want %0d", rx_cnt[0], c0 + 3); else passes++;
    checks++; if (rx_hist0[c0] !== 8'h11) $display("FAIL burst_rx0: got %h want 11", rx_hist0[c0]); else passes++;
    checks++; if (rx_hist0[c0 + 1] !== 8'h22) $display("FAIL burst_rx1: got %h want 22", rx_hist0[c0 + 1]); else passes++;
    checks++; if (rx_hist0[c0 + 2] !== 8'h33) $display("FAIL burst_rx2: got %h want 33", rx_hist0[c0 + 2]); else passes++;
    checks++; if (m1 !== 8'hAA) $display("FAIL burst_miso0: got %h want aa", m1); else passes++;
    checks++; if (m2 !== 8'hBB) $display("FAIL burst_miso1: got %h want bb", m2); else passes++;
    checks++; if (m3 !== 8'hFF) $display("FAIL burst_miso2: got %h want ff", m3); else passes++;
  endtask

  task automatic test_tx_ignore();
    logic [7:0] mi;
    load_tx(0, 8'h10);
    checks++; if (ready[0] !== 1'b0) $display("FAIL txdv_ready_low: got %b want 0", ready[0]); else passes++;
    load_tx(0, 8'h20);
    xfer(0, 8'h00, mi);
    checks++; if (mi !== 8'h10) $display("FAIL txdv_first_kept: got %h want 10", mi); else passes++;
    checks++; if (ready[0] !== 1'b1) $display("FAIL txdv_ready_after: got %b want 1", ready[0]); else passes++;
    xfer(0, 8'h00, mi);
    checks++; if (mi !== 8'hFF) $display("FAIL txdv_second_dropped: got %h want ff", mi); else passes++;
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    int c0;
    c0 = rx_cnt[0];
    load_tx(0, 8'hC3);
    cs_n[0] = 1'b0;
    #HALF;
    spi_bits(0, 8'hF0, 4, mi);
    #HALF;
    cs_n[0] = 1'b1;
    #(4 * HALF);
    checks++; if (rx_cnt[0] !== c0) $display("FAIL partial_no_rx: got %0d want %0d", rx_cnt[0], c0); else passes++;
    checks++; if (miso[0] !== 1'b0 && miso[0] !== 1'bz) $display("FAIL partial_miso_idle: got %b want 0/z", miso[0]); else passes++;
    checks++; if (csa[0] !== 1'b0) $display("FAIL partial_cs_active: got %b want 0", csa[0]); else passes++;
    load_tx(0, 8'h96);
    xfer(0, 8'h5A, mi);
    checks++; if (rx_cnt[0] !== c0 + 1 || rx_last[0] !== 8'h5A) $display("FAIL partial_next_rx: got %h (n=%0d) want 5a", rx_last[0], rx_cnt[0] - c0); else passes++;
    checks++; if (mi !== 8'h96) $display("FAIL partial_next_miso: got %h want 96", mi); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    int c0;
    cs_n[0] = 1'b0;
    #HALF;
    load_tx(0, 8'hE7);
    spi_bits(0, 8'h0F, 4, mi);
    @(posedge clk); #3;
    rst_l = 1'b0;
    #2;
    checks++; if (csa[0] !== 1'b0) $display("FAIL rstmid_cs_active: got %b want 0", csa[0]); else passes++;
    checks++; if (ready[0] !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready[0]); else passes++;
    checks++; if (rx_byte[0] !== 8'h00) $display("FAIL rstmid_rx_byte: got %h want 00", rx_byte[0]); else passes++;
    checks++; if (rx_dv[0] !== 1'b0) $display("FAIL rstmid_rx_dv: got %b want 0", rx_dv[0]); else passes++;
    checks++; if (miso[0] !== 1'b0 && miso[0] !== 1'bz) $display("FAIL rstmid_miso: got %b want 0/z", miso[0]); else passes++;
    cs_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (4) @(posedge clk);
    c0 = rx_cnt[0];
    load_tx(0, 8'h69);
    xfer(0, 8'h96, mi);
    checks++; if (rx_cnt[0] !== c0 + 1 || rx_last[0] !== 8'h96) $display("FAIL rstmid_next_rx: got %h (n=%0d) want 96", rx_last[0], rx_cnt[0] - c0); else passes++;
    checks++; if (mi !== 8'h69) $display("FAIL rstmid_next_miso: got %h want 69", mi); else passes++;
  endtask

  initial begin
    rst_l = 1'b0;
    sck   = 4'b1100;
    cs_n  = 4'hF;
    tx_dv = 4'h0;
    mosi  = 1'b0;
    for (int k = 0; k < 4; k++) tx_byte[k] = 8'h00;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_tx_ignore();
    test_partial();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
